// File: rtl/noc_pkg.sv
// Shared NoC defaults and the output-port FSM encoding.
package noc_pkg;
    localparam int DEF_N_REQ        = 4;
    localparam int DEF_CREDIT_DEPTH = 4;
    localparam int DEF_CNT_W        = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } port_state_t;
endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester after last_idx, with wrap.
module rr_select
    import noc_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_onehot = '0;
        win_idx    = '0;
        any        = 1'b0;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_idx) + k) % N_REQ);
            if (!any && req[cand]) begin
                any              = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: round-robin packet lock plus credit-based
// flow control toward the downstream buffer.
module output_port_allocator
    import noc_pkg::*;
#(
    parameter  int N_REQ        = DEF_N_REQ,
    parameter  int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
    parameter  int CNT_W        = DEF_CNT_W,
    localparam int IDX_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] tail,
    input  logic             credit_in,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             fwd_valid,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             busy,
    output logic             credit_err
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDIT_DEPTH);

    port_state_t      state, state_nxt;
    logic [N_REQ-1:0] gnt_q;
    logic [IDX_W-1:0] owner, last_idx;
    logic [N_REQ-1:0] win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic             pkt_done;

    rr_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req        (req),
        .last_idx   (last_idx),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any        (win_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_any)  state_nxt = LOCKED;
            LOCKED:  if (pkt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration ignores credits; a locked owner with no credit just stalls.
    always_comb begin
        busy      = (state == LOCKED);
        gnt       = gnt_q;
        gnt_idx   = owner;
        fwd_valid = busy && req[owner] && (credit_cnt != '0);
        pkt_done  = fwd_valid && tail[owner];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q    <= '0;
            owner    <= '0;
            last_idx <= IDX_W'(N_REQ - 1);
        end else if (state == IDLE && win_any) begin
            gnt_q <= win_onehot;
            owner <= win_idx;
        end else if (pkt_done) begin
            gnt_q    <= '0;
            last_idx <= owner;
        end
    end

    // A forward and a returning credit in the same cycle cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_cnt <= FULL;
            credit_err <= 1'b0;
        end else if (fwd_valid && !credit_in) begin
            credit_cnt <= credit_cnt - 1'b1;
        end else if (!fwd_valid && credit_in) begin
            if (credit_cnt == FULL) credit_err <= 1'b1;
            else                    credit_cnt <= credit_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_output_port_allocator.sv
// Bench for output_port_allocator: directed scenarios with literal expectations
// plus randomized traffic checked each cycle against a packet-level model.
module tb_output_port_allocator;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] req, tail;
    logic         credit_in;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         fwd_valid, busy, credit_err;
    logic [2:0]   credit_cnt;

    int pass_cnt = 0;
    int total    = 0;

    output_port_allocator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .tail       (tail),
        .credit_in  (credit_in),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .fwd_valid  (fwd_valid),
        .credit_cnt (credit_cnt),
        .busy       (busy),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset_n   = 1'b0;
        req       = '0;
        tail      = '0;
        credit_in = 1'b0;
        tick();
        reset_n   = 1'b1;
    endtask

    // Packet-level model: owner index (-1 = port free), last winner, credits.
    int m_owner, m_last, m_cnt;
    bit m_err;

    initial begin
        m_owner = -1; m_last = N - 1; m_cnt = DEPTH; m_err = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_owner = -1; m_last = N - 1; m_cnt = DEPTH; m_err = 0;
                chk("rst_gnt", int'(gnt), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_fwd", int'(fwd_valid), 0);
                chk("rst_cnt", int'(credit_cnt), DEPTH);
                chk("rst_err", int'(credit_err), 0);
            end else begin
                bit       e_busy, e_fwd;
                int       e_gnt;
                e_busy = (m_owner >= 0);
                e_gnt  = e_busy ? (1 << m_owner) : 0;
                e_fwd  = e_busy && req[m_owner] && (m_cnt > 0);
                chk("m_busy", int'(busy), int'(e_busy));
                chk("m_gnt", int'(gnt), e_gnt);
                chk("m_fwd", int'(fwd_valid), int'(e_fwd));
                chk("m_cnt", int'(credit_cnt), m_cnt);
                chk("m_err", int'(credit_err), int'(m_err));
                if (e_busy) chk("m_idx", int'(gnt_idx), m_owner);
                if (m_owner < 0) begin
                    for (int k = 1; k <= N; k++) begin
                        int c;
                        c = (m_last + k) % N;
                        if (m_owner < 0 && req[c]) m_owner = c;
                    end
                end else if (e_fwd && tail[m_owner]) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
                if (e_fwd && !credit_in) m_cnt--;
                else if (!e_fwd && credit_in) begin
                    if (m_cnt == DEPTH) m_err = 1;
                    else m_cnt++;
                end
            end
        end
    end

    initial begin
        int exp30[10];
        int nf;
        exp30 = '{0, 1, 0, 2, 0, 4, 0, 8, 0, 1};
        reset_n = 1'b0; req = '0; tail = '0; credit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Round-robin with single-flit packets; 5th grant stalls on zero credit.
        req = 4'hF; tail = 4'hF;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            chk($sformatf("rr_gnt%0d", i), int'(gnt), exp30[i]);
        end
        chk("rr_cnt", int'(credit_cnt), 0);
        chk("rr_fwd_stall", int'(fwd_valid), 0);

        // Lock holds against a late higher-index requester until the tail.
        do_reset();
        req = 4'b0010; tail = '0;
        at_neg(); chk("wh_idle", int'(gnt), 0);
        tick(); req = 4'b1010;
        at_neg(); chk("wh_f1", int'(gnt), 2); chk("wh_f1v", int'(fwd_valid), 1);
        tick();
        at_neg(); chk("wh_f2", int'(gnt), 2);
        tick(); tail = 4'b0010;
        at_neg(); chk("wh_f3", int'(gnt), 2); chk("wh_f3v", int'(fwd_valid), 1);
        tick(); tail = '0;
        at_neg(); chk("wh_bubble", int'(gnt), 0);
        tick();
        at_neg(); chk("wh_next", int'(gnt), 8);
        req = '0;

        // Six-flit packet against four credits.
        do_reset();
        req = 4'b0001; tail = '0; nf = 0;
        repeat (8) begin at_neg(); nf += int'(fwd_valid); tick(); end
        chk("cr_first4", nf, 4);
        chk("cr_stall_cnt", int'(credit_cnt), 0);
        chk("cr_stall_busy", int'(busy), 1);
        nf = 0;
        credit_in = 1'b1; tick(); credit_in = 1'b0;
        repeat (3) begin at_neg(); nf += int'(fwd_valid); tick(); end
        tail = 4'b0001;
        credit_in = 1'b1; tick(); credit_in = 1'b0;
        repeat (3) begin at_neg(); nf += int'(fwd_valid); tick(); end
        chk("cr_last2", nf, 2);
        chk("cr_end_cnt", int'(credit_cnt), 0);
        req = '0; tail = '0;

        // Forward and credit return in the same cycle at cnt=2.
        do_reset();
        req = 4'b0001;
        at_neg(); tick();
        at_neg(); chk("sim_c4", int'(credit_cnt), 4); tick();
        at_neg(); chk("sim_c3", int'(credit_cnt), 3); tick();
        credit_in = 1'b1;
        at_neg(); chk("sim_c2", int'(credit_cnt), 2); chk("sim_fwd", int'(fwd_valid), 1);
        tick(); credit_in = 1'b0; req = '0;
        at_neg(); chk("sim_hold", int'(credit_cnt), 2);

        // Credit overflow at full is sticky until reset.
        do_reset();
        credit_in = 1'b1; tick(); credit_in = 1'b0;
        at_neg(); chk("ovf_cnt", int'(credit_cnt), 4); chk("ovf_err", int'(credit_err), 1);
        repeat (3) tick();
        at_neg(); chk("ovf_sticky", int'(credit_err), 1);
        do_reset();
        at_neg(); chk("ovf_clr", int'(credit_err), 0);

        // Reset mid-packet at cnt=1, then priority restarts from input 0.
        do_reset();
        req = 4'b0100;
        repeat (4) tick();
        chk("mr_cnt1", int'(credit_cnt), 1);
        chk("mr_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("mr_gnt0", int'(gnt), 0);
        chk("mr_busy0", int'(busy), 0);
        chk("mr_fwd0", int'(fwd_valid), 0);
        chk("mr_cnt4", int'(credit_cnt), 4);
        req = 4'b0110;
        tick(); reset_n = 1'b1;
        tick();
        at_neg(); chk("mr_first", int'(gnt), 2);

        // Random traffic with occasional resets, checked by the model.
        do_reset();
        repeat (3000) begin
            req       = N'($urandom);
            tail      = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            credit_in = ($urandom_range(0, 2) == 0);
            reset_n   = ($urandom_range(0, 399) != 0);
            tick();
        end
        reset_n = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
